// File: rtl/hv_pkg.sv
// Shared definitions for the hypervector job sequencer.
//   state_e            : sequencer states (IDLE, INIT, GAP, RUN, FLUSH)
//   ITEM_W/ADDR_W/...  : default widths used by the top and the stall timer
package hv_pkg;

  localparam int ITEM_W = 16;  // item count and mat_a width
  localparam int ADDR_W = 20;  // addr_i / addr_j width
  localparam int BEAT_W = 16;  // output beat counter width
  localparam int TMO_W  = 24;  // stall timeout counter width

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_GAP   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage

// File: rtl/hv_stall_timer.sv
// Stall watchdog for the RUN phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : counting enabled (sequencer in RUN)
//   hs_i       : output beat handshake this cycle (restarts the count)
//   tmo_i      : timeout in stall cycles, 0 disables the watchdog
//   expire_o   : this cycle is the tmo_i-th consecutive stall cycle
module hv_stall_timer
  import hv_pkg::*;
#(
  parameter int TMO_W = hv_pkg::TMO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             hs_i,
  input  logic [TMO_W-1:0] tmo_i,
  output logic             expire_o
);

  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of stall cycles already completed, so the current
  // cycle is stall number cnt_q+1; compare against tmo-1 to avoid overflow.
  assign expire_o = en_i && !hs_i && (tmo_i != '0) && (cnt_q == tmo_i - TMO_ONE);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || hs_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + TMO_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hv_job_sequencer.sv
// Sequences one hypervector encoding job: item-memory initialisation
// (matw/mat_a), a one-cycle settle gap, then the streaming run phase
// (run/last) until the last output beat, a stall timeout or an abort.
//   AXIS_ACLK, AXIS_ARESETN        : clock, asynchronous active-low reset
//   start, abort, clear            : one-cycle pulses from the register block
//   cfg_items/addr_i/addr_j/last/tmo : job geometry, latched on accepted start
//   dst_valid/dst_ready/dst_last   : output stream handshake being observed
//   matw, mat_a                    : item-memory write enable / address
//   run, last                      : datapath run enable, latched last-job flag
//   addr_i, addr_j                 : latched loop bounds
//   busy, done, err, beats, irq    : status towards the register file
module hv_job_sequencer
  import hv_pkg::*;
#(
  parameter int ITEM_W = hv_pkg::ITEM_W,
  parameter int ADDR_W = hv_pkg::ADDR_W,
  parameter int BEAT_W = hv_pkg::BEAT_W,
  parameter int TMO_W  = hv_pkg::TMO_W
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic              clear,
  input  logic [ITEM_W-1:0] cfg_items,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              cfg_last,
  input  logic [TMO_W-1:0]  cfg_tmo,
  input  logic              dst_valid,
  input  logic              dst_ready,
  input  logic              dst_last,
  output logic              matw,
  output logic [ITEM_W-1:0] mat_a,
  output logic              run,
  output logic              last,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BEAT_W-1:0] beats,
  output logic              irq
);

  localparam logic [ITEM_W-1:0] ITEM_ONE = ITEM_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

  state_e            state_q;
  logic [ITEM_W-1:0] items_q, mat_a_q;
  logic [ADDR_W-1:0] addr_i_q, addr_j_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [BEAT_W-1:0] beats_q;
  logic              matw_q, run_q, last_q, done_q, err_q, irq_q;

  logic hs, tmo_expire, abort_evt, tmo_evt, done_evt, end_evt;

  // Beats are only counted in RUN; the FLUSH cycle merely lets the final
  // handshake drain through the datapath.
  assign hs = (state_q == ST_RUN) && dst_valid && dst_ready;

  hv_stall_timer #(
    .TMO_W(TMO_W)
  ) u_stall_timer (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .en_i    (state_q == ST_RUN),
    .hs_i    (hs),
    .tmo_i   (tmo_q),
    .expire_o(tmo_expire)
  );

  // Termination priority: abort, then timeout, then normal completion.
  assign abort_evt = abort && (state_q != ST_IDLE);
  assign tmo_evt   = tmo_expire && !abort_evt;
  assign done_evt  = (state_q == ST_FLUSH) && !abort_evt;
  assign end_evt   = abort_evt || tmo_evt || done_evt;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q  <= ST_IDLE;
      items_q  <= '0;
      mat_a_q  <= '0;
      addr_i_q <= '0;
      addr_j_q <= '0;
      tmo_q    <= '0;
      beats_q  <= '0;
      matw_q   <= 1'b0;
      run_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= end_evt;

      // A set event later in this block overrides the clear.
      if (clear) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end

      if (hs && !abort_evt && (beats_q != '1)) begin
        beats_q <= beats_q + BEAT_ONE;
      end

      if (end_evt) begin
        state_q <= ST_IDLE;
        matw_q  <= 1'b0;
        mat_a_q <= '0;
        run_q   <= 1'b0;
        last_q  <= 1'b0;
        if (done_evt) done_q <= 1'b1;
        else          err_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              items_q  <= cfg_items;
              addr_i_q <= cfg_addr_i;
              addr_j_q <= cfg_addr_j;
              tmo_q    <= cfg_tmo;
              last_q   <= cfg_last;
              beats_q  <= '0;
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              matw_q   <= 1'b1;
              mat_a_q  <= '0;
              state_q  <= ST_INIT;
            end
          end
          ST_INIT: begin
            if (mat_a_q == items_q) begin
              matw_q  <= 1'b0;
              mat_a_q <= '0;
              state_q <= ST_GAP;
            end else begin
              mat_a_q <= mat_a_q + ITEM_ONE;
            end
          end
          ST_GAP: begin
            run_q   <= 1'b1;
            state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (hs && dst_last) state_q <= ST_FLUSH;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign matw   = matw_q;
  assign mat_a  = mat_a_q;
  assign run    = run_q;
  assign last   = last_q;
  assign addr_i = addr_i_q;
  assign addr_j = addr_j_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign beats  = beats_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_hv_job_sequencer.sv
// Self-checking bench for hv_job_sequencer. Expected mat_a sequences and job
// outcomes are queued when a job is started and consumed as the DUT produces
// them; outputs are sampled 1 time unit after each rising clock edge.
module tb_hv_job_sequencer;

  localparam int IW = 16;
  localparam int AW = 20;
  localparam int BW = 16;
  localparam int TW = 24;
  localparam int CYC_LIMIT = 2000;

  logic          AXIS_ACLK = 1'b0;
  logic          AXIS_ARESETN = 1'b0;
  logic          start, abort, clear;
  logic [IW-1:0] cfg_items;
  logic [AW-1:0] cfg_addr_i, cfg_addr_j;
  logic          cfg_last;
  logic [TW-1:0] cfg_tmo;
  logic          dst_valid, dst_ready, dst_last;
  logic          matw, run, last, busy, done, err, irq;
  logic [IW-1:0] mat_a;
  logic [AW-1:0] addr_i, addr_j;
  logic [BW-1:0] beats;

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  hv_job_sequencer #(
    .ITEM_W(IW), .ADDR_W(AW), .BEAT_W(BW), .TMO_W(TW)
  ) dut (
    .AXIS_ACLK   (AXIS_ACLK),
    .AXIS_ARESETN(AXIS_ARESETN),
    .start       (start),
    .abort       (abort),
    .clear       (clear),
    .cfg_items   (cfg_items),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_addr_j  (cfg_addr_j),
    .cfg_last    (cfg_last),
    .cfg_tmo     (cfg_tmo),
    .dst_valid   (dst_valid),
    .dst_ready   (dst_ready),
    .dst_last    (dst_last),
    .matw        (matw),
    .mat_a       (mat_a),
    .run         (run),
    .last        (last),
    .addr_i      (addr_i),
    .addr_j      (addr_j),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .beats       (beats),
    .irq         (irq)
  );

  typedef struct {
    bit done;
    bit err;
    int beats;  // -1: not checked
  } job_t;

  int   exp_mata_q[$];
  job_t exp_job_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge AXIS_ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; clear = 1'b0;
    dst_valid = 1'b0; dst_ready = 1'b0; dst_last = 1'b0;
  endtask

  // Runs one job from start to termination and checks it on the way.
  task automatic drive_job(input string name, input int items, input int ai, input int aj,
                           input bit lst, input int tmo, input int nbeats, input bit rdy,
                           input int abort_at, input bit poke_start, input bit clear_at_flush);
    job_t exp;
    int   matw_n = 0, gap_n = 0, run_n = 0, irq_n = 0, hs_n = 0, cyc = 0, m;
    bit   sent_last = 0, flush_next = 0, irq_at_end;

    if (abort_at > 0)         exp = '{done: 1'b0, err: 1'b1, beats: -1};
    else if (!rdy && tmo > 0) exp = '{done: 1'b0, err: 1'b1, beats: 0};
    else                      exp = '{done: 1'b1, err: 1'b0, beats: nbeats};
    exp_job_q.push_back(exp);
    for (int k = 0; k <= items; k++) exp_mata_q.push_back(k);

    cfg_items = IW'(items); cfg_addr_i = AW'(ai); cfg_addr_j = AW'(aj);
    cfg_last = lst; cfg_tmo = TW'(tmo);
    start = 1'b1;
    tick();
    start = 1'b0;

    n_tests++;
    if ({busy, matw, done, err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL %s start_accept: busy/matw/done/err=%b expected 1100", name, {busy, matw, done, err});
    end

    while (busy && cyc < CYC_LIMIT) begin
      if (irq) irq_n++;
      if (matw) begin
        matw_n++;
        m = (exp_mata_q.size() > 0) ? exp_mata_q.pop_front() : -1;
        n_tests++;
        if (int'(mat_a) != m) begin
          n_fail++;
          $display("FAIL %s mat_a: got %0d expected %0d", name, mat_a, m);
        end
      end
      if (!matw && !run) gap_n++;
      if (run) run_n++;

      if (run && run_n == 1) begin
        n_tests++;
        if ({last, addr_i, addr_j, matw} !== {lst, AW'(ai), AW'(aj), 1'b0}) begin
          n_fail++;
          $display("FAIL %s run_entry: last=%b addr_i=%0d addr_j=%0d matw=%b expected %b %0d %0d 0",
                   name, last, addr_i, addr_j, matw, lst, ai, aj);
        end
      end

      // Drive the inputs for the next edge.
      clear = 1'b0; abort = 1'b0; dst_last = 1'b0;
      start = poke_start && matw && (matw_n == 2);
      cfg_addr_i = start ? AW'(777) : AW'(ai);
      if (flush_next) begin
        flush_next = 0;
        n_tests++;
        if (run !== 1'b1) begin
          n_fail++;
          $display("FAIL %s flush_run: got %b expected 1", name, run);
        end
        if (clear_at_flush) clear = 1'b1;
      end
      if (run && !sent_last) begin
        dst_valid = 1'b1;
        dst_ready = rdy;
        if (abort_at > 0 && run_n == abort_at) begin
          abort = 1'b1;
          dst_last = 1'b1;
        end else if (rdy) begin
          hs_n++;
          if (hs_n == nbeats) begin
            dst_last = 1'b1; sent_last = 1; flush_next = 1;
          end
        end
      end else begin
        dst_valid = 1'b0;
        dst_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    idle_inputs();

    n_tests++;
    if (cyc >= CYC_LIMIT) begin
      n_fail++;
      $display("FAIL %s job_end: still busy after %0d cycles, expected termination", name, cyc);
    end

    irq_at_end = irq;
    if (irq) irq_n++;
    n_tests++;
    if ({irq_at_end, run, matw, last} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s end_outputs: irq/run/matw/last=%b expected 1000", name, {irq_at_end, run, matw, last});
    end
    repeat (2) begin
      tick();
      if (irq) irq_n++;
    end
    n_tests++;
    if (irq_n != 1) begin
      n_fail++;
      $display("FAIL %s irq_count: got %0d expected 1", name, irq_n);
    end

    exp = exp_job_q.pop_front();
    n_tests++;
    if ({done, err} !== {exp.done, exp.err}) begin
      n_fail++;
      $display("FAIL %s flags: done=%b err=%b expected %b %b", name, done, err, exp.done, exp.err);
    end
    if (exp.beats >= 0) begin
      n_tests++;
      if (int'(beats) != exp.beats) begin
        n_fail++;
        $display("FAIL %s beats: got %0d expected %0d", name, beats, exp.beats);
      end
    end
    n_tests++;
    if (matw_n != items + 1 || gap_n != 1 || exp_mata_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s phases: matw cycles=%0d gap=%0d leftover=%0d expected %0d 1 0",
               name, matw_n, gap_n, exp_mata_q.size(), items + 1);
    end
    if (!rdy && tmo > 0) begin
      n_tests++;
      if (run_n != tmo) begin
        n_fail++;
        $display("FAIL %s timeout_run_cycles: got %0d expected %0d", name, run_n, tmo);
      end
    end
    n_tests++;
    if (addr_i !== AW'(ai)) begin
      n_fail++;
      $display("FAIL %s addr_i_hold: got %0d expected %0d", name, addr_i, ai);
    end
    exp_mata_q.delete();
  endtask

  task automatic test_reset();
    int cyc = 0;
    idle_inputs();
    cfg_items = '0; cfg_addr_i = '0; cfg_addr_j = '0; cfg_last = 1'b0; cfg_tmo = '0;
    AXIS_ARESETN = 1'b0;
    repeat (3) tick();
    AXIS_ARESETN = 1'b1;
    tick();
    n_tests++;
    if ({matw, mat_a, run, last, addr_i, addr_j, busy, done, err, beats, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b matw=%b mat_a=%0d expected all outputs 0", busy, matw, mat_a);
    end

    // Reset while INIT is writing the item memory.
    cfg_items = IW'(50); cfg_addr_i = AW'(5); cfg_addr_j = AW'(6); cfg_last = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (mat_a != IW'(20) && cyc < 200) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (matw !== 1'b1 || mat_a !== IW'(20)) begin
      n_fail++;
      $display("FAIL reset_reach_init: matw=%b mat_a=%0d expected 1 20", matw, mat_a);
    end
    AXIS_ARESETN = 1'b0;
    #1;
    n_tests++;
    if ({matw, mat_a, run, last, addr_i, addr_j, busy, done, err, beats, irq} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b matw=%b mat_a=%0d addr_i=%0d expected all outputs 0",
               busy, matw, mat_a, addr_i);
    end
    tick();
    AXIS_ARESETN = 1'b1;
    tick();
    n_tests++;
    if ({busy, matw, run} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: busy/matw/run=%b expected 000", {busy, matw, run});
    end
  endtask

  task automatic test_nominal();
    drive_job("nominal", 100, 29, 2, 1'b1, 0, 30, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_items();
    drive_job("zero_items", 0, 7, 9, 1'b0, 0, 3, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    drive_job("timeout", 4, 3, 4, 1'b0, 16, 100, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    drive_job("abort", 2, 11, 12, 1'b1, 0, 100, 1'b1, 5, 1'b0, 1'b0);
  endtask

  task automatic test_busy_start_and_clear();
    drive_job("busy_start_clear", 3, 40, 41, 1'b0, 0, 3, 1'b1, 0, 1'b1, 1'b1);
    // A clear on its own drops the sticky flag without an interrupt.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_tests++;
    if ({done, err, irq, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear_idle: done/err/irq/busy=%b expected 0000", {done, err, irq, busy});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_items();
    test_timeout();
    test_abort();
    test_busy_start_and_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
